// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: shares one 8x8 signed shift-add multiplier between two
// requesters using round-robin grant, a start pulse, a done wait and a response.
//
// Ports:
//   Clk, Reset          clock (rising edge), synchronous active-high reset
//   req{0,1}_valid/a/b  operand request (a = multiplicand, b = multiplier)
//   req{0,1}_ready      operands accepted this cycle (IDLE, granted side only)
//   rsp{0,1}_valid/data product response for that requester
//   rsp{0,1}_ready      requester takes the response
//   rsp_err             qualifies the active rsp*_valid; 1 = job aborted
//   mult_start          one-cycle start pulse to the datapath
//   mult_a, mult_b      operands to the datapath, stable ISSUE through WAIT
//   mult_done           datapath completion pulse
//   mult_result         datapath product, valid with mult_done
//   busy                high whenever the arbiter is not IDLE
//
// Optional build macro: MULT_SHARE_TIMEOUT_EN adds a WAIT watchdog that aborts
// the job after TIMEOUT cycles and returns result 0 with rsp_err=1.

module mult_share_arbiter #(
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 32
) (
    input  logic                  Clk,
    input  logic                  Reset,

    input  logic                  req0_valid,
    input  logic [DATA_W-1:0]     req0_a,
    input  logic [DATA_W-1:0]     req0_b,
    output logic                  req0_ready,

    input  logic                  req1_valid,
    input  logic [DATA_W-1:0]     req1_a,
    input  logic [DATA_W-1:0]     req1_b,
    output logic                  req1_ready,

    output logic                  rsp0_valid,
    output logic [2*DATA_W-1:0]   rsp0_data,
    input  logic                  rsp0_ready,

    output logic                  rsp1_valid,
    output logic [2*DATA_W-1:0]   rsp1_data,
    input  logic                  rsp1_ready,

    output logic                  rsp_err,

    output logic                  mult_start,
    output logic [DATA_W-1:0]     mult_a,
    output logic [DATA_W-1:0]     mult_b,
    input  logic                  mult_done,
    input  logic [2*DATA_W-1:0]   mult_result,

    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t state;
    state_t state_next;

    logic [DATA_W-1:0]   op_a;
    logic [DATA_W-1:0]   op_b;
    logic [2*DATA_W-1:0] result;
    logic                owner;
    logic                last_grant;
    logic                err;

    logic grant0;
    logic grant1;
    logic accept;
    logic rsp_hs;
    logic timeout;

    // Grant only in IDLE. On contention the side that did not win last
    // time gets it; last_grant resets to 1 so requester 0 wins first.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == IDLE) begin
            if (req0_valid && req1_valid) begin
                grant0 = last_grant;
                grant1 = ~last_grant;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    // A grant is only raised toward a valid requester, so grant == handshake.
    assign accept = grant0 | grant1;

    assign rsp_hs = (state == RESP) &&
                    (owner ? rsp1_ready : rsp0_ready);

`ifdef MULT_SHARE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wait_cnt;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            wait_cnt <= '0;
        end else if (state == ISSUE) begin
            wait_cnt <= '0;
        end else if (state == WAIT) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    // Fires on the TIMEOUT-th WAIT cycle; mult_done in that cycle still wins.
    assign timeout = (state == WAIT) &&
                     (wait_cnt == CNT_W'(TIMEOUT - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                state_next = WAIT;
            end
            WAIT: begin
                if (mult_done || timeout) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_hs) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Job data. Operand registers hold their last value across IDLE so the
    // datapath inputs never glitch between jobs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            op_a       <= '0;
            op_b       <= '0;
            result     <= '0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            err        <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        op_a  <= grant1 ? req1_a : req0_a;
                        op_b  <= grant1 ? req1_b : req0_b;
                        owner <= grant1;
                    end
                end
                WAIT: begin
                    if (mult_done) begin
                        result <= mult_result;
                        err    <= 1'b0;
                    end else if (timeout) begin
                        result <= '0;
                        err    <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_hs) begin
                        last_grant <= owner;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    assign rsp0_valid = (state == RESP) && !owner;
    assign rsp1_valid = (state == RESP) && owner;
    assign rsp0_data  = result;
    assign rsp1_data  = result;
    assign rsp_err    = err;

    assign mult_start = (state == ISSUE);
    assign mult_a     = op_a;
    assign mult_b     = op_b;

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb_mult_share_arbiter: directed table-driven bench for mult_share_arbiter
// with a small delayed-done datapath model.

`timescale 1ns/1ps

module tb_mult_share_arbiter;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        req0_valid, req1_valid;
    logic [7:0]  req0_a, req0_b, req1_a, req1_b;
    logic        req0_ready, req1_ready;
    logic        rsp0_valid, rsp1_valid;
    logic [15:0] rsp0_data, rsp1_data;
    logic        rsp0_ready, rsp1_ready;
    logic        rsp_err;
    logic        mult_start;
    logic [7:0]  mult_a, mult_b;
    logic        mult_done;
    logic [15:0] mult_result;
    logic        busy;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 Clk = ~Clk;

    mult_share_arbiter #(.DATA_W(8), .TIMEOUT(32)) dut (
        .Clk(Clk), .Reset(Reset),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b),
        .req1_ready(req1_ready),
        .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
        .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
        .rsp1_ready(rsp1_ready),
        .rsp_err(rsp_err),
        .mult_start(mult_start), .mult_a(mult_a), .mult_b(mult_b),
        .mult_done(mult_done), .mult_result(mult_result),
        .busy(busy)
    );

    // Datapath model: done pulse 9 cycles after start with the signed product.
    logic        model_en   = 1'b1;
    logic        force_done = 1'b0;
    logic [15:0] force_res  = '0;
    int          dcnt       = -1;
    logic signed [15:0] pa, pb;
    logic [15:0] model_res;

    initial begin
        mult_done   = 1'b0;
        mult_result = '0;
        forever begin
            @(negedge Clk);
            mult_done = force_done;
            if (force_done) mult_result = force_res;
            if (dcnt > 0) begin
                dcnt--;
                if (dcnt == 0) begin
                    mult_done   = 1'b1;
                    mult_result = model_res;
                    dcnt        = -1;
                end
            end
            if (model_en && mult_start) begin
                pa        = $signed(mult_a);
                pb        = $signed(mult_b);
                model_res = pa * pb;
                dcnt      = 9;
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic rdy(input int s);
        return s != 0 ? req1_ready : req0_ready;
    endfunction

    function automatic logic rspv(input int s);
        return s != 0 ? rsp1_valid : rsp0_valid;
    endfunction

    function automatic logic [15:0] rspd(input int s);
        return s != 0 ? rsp1_data : rsp0_data;
    endfunction

    task automatic set_req(input int s, input logic v,
                           input logic [7:0] a, input logic [7:0] b);
        if (s != 0) begin
            req1_valid = v; req1_a = a; req1_b = b;
        end else begin
            req0_valid = v; req0_a = a; req0_b = b;
        end
    endtask

    task automatic set_rsp_ready(input int s, input logic v);
        if (s != 0) rsp1_ready = v;
        else rsp0_ready = v;
    endtask

    // Called at a negedge with the DUT idle; leaves it idle again.
    task automatic run_job(input int s, input logic [7:0] a,
                           input logic [7:0] b, input logic [15:0] exp,
                           input string nm);
        int n;
        set_req(s, 1'b1, a, b);
        n = 0;
        #1;
        while (!rdy(s) && n < 50) begin
            @(negedge Clk); #1; n++;
        end
        check({nm, "_ready"}, rdy(s), 1'b1);
        @(negedge Clk);
        set_req(s, 1'b0, a, b);
        check({nm, "_start"}, mult_start, 1'b1);
        check({nm, "_ops"}, {mult_a, mult_b}, {a, b});
        check({nm, "_ready_drop"}, {req0_ready, req1_ready}, 2'b00);
        n = 0;
        while (!rspv(s) && n < 100) begin
            @(negedge Clk); n++;
        end
        check({nm, "_rsp_valid"}, rspv(s), 1'b1);
        check({nm, "_rsp_data"}, rspd(s), exp);
        check({nm, "_rsp_err"}, rsp_err, 1'b0);
        check({nm, "_other_valid"}, rspv(1 - s), 1'b0);
        set_rsp_ready(s, 1'b1);
        @(negedge Clk);
        set_rsp_ready(s, 1'b0);
        check({nm, "_idle"}, {busy, rsp0_valid, rsp1_valid}, 3'b000);
    endtask

    typedef struct {
        int         sel;
        logic [7:0] a;
        logic [7:0] b;
        logic [15:0] exp;
        string      nm;
    } vec_t;

    vec_t vecs[6];
    int   grants[4];

    initial begin
        int n, ng;
        logic bad;

        vecs[0] = '{0, 8'h03, 8'h05, 16'h000F, "v_3x5"};
        vecs[1] = '{1, 8'h04, 8'h04, 16'h0010, "v_4x4"};
        vecs[2] = '{0, 8'hFE, 8'h07, 16'hFFF2, "v_m2x7"};
        vecs[3] = '{1, 8'h80, 8'h80, 16'h4000, "v_min_sq"};
        vecs[4] = '{0, 8'h7F, 8'h81, 16'hC0FF, "v_max_min"};
        vecs[5] = '{1, 8'hFF, 8'hFF, 16'h0001, "v_m1_sq"};

        Reset = 1'b1;
        req0_valid = 0; req0_a = 0; req0_b = 0;
        req1_valid = 0; req1_a = 0; req1_b = 0;
        rsp0_ready = 0; rsp1_ready = 0;
        @(negedge Clk);
        @(negedge Clk);
        check("rst_busy", busy, 1'b0);
        check("rst_start", mult_start, 1'b0);
        check("rst_ops", {mult_a, mult_b}, 16'h0000);
        check("rst_rsp", {rsp0_valid, rsp1_valid, rsp_err}, 3'b000);
        check("rst_data", rsp0_data, 16'h0000);
        Reset = 1'b0;

        // Continuous contention from reset: expect 0,1,0,1.
        set_req(0, 1'b1, 8'h02, 8'h02);
        set_req(1, 1'b1, 8'h04, 8'h04);
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        ng = 0;
        n  = 0;
        while (ng < 4 && n < 200) begin
            #1;
            if (req0_ready && req1_ready) begin
                check("cont_dual_ready", 1'b1, 1'b0);
            end else if (req0_ready || req1_ready) begin
                grants[ng] = req1_ready ? 1 : 0;
                ng++;
            end
            if (rsp0_valid) check("cont_rsp0", rsp0_data, 16'h0004);
            if (rsp1_valid) check("cont_rsp1", rsp1_data, 16'h0010);
            @(negedge Clk);
            n++;
        end
        check("cont_grants", ng, 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("cont_order%0d", i), grants[i], i % 2);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            @(negedge Clk); n++;
        end
        check("cont_idle", busy, 1'b0);
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_job(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].nm);
        end

        // Backpressure on rsp0 with req1 pending.
        set_req(0, 1'b1, 8'h11, 8'h03);
        n = 0;
        #1;
        while (!req0_ready && n < 50) begin
            @(negedge Clk); #1; n++;
        end
        check("bp_ready0", req0_ready, 1'b1);
        @(negedge Clk);
        req0_valid = 1'b0;
        n = 0;
        while (!rsp0_valid && n < 100) begin
            @(negedge Clk); n++;
        end
        set_req(1, 1'b1, 8'h05, 8'h06);
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("bp_hold%0d", i),
                  {rsp0_valid, rsp0_data, req1_ready, mult_start},
                  {1'b1, 16'h0033, 1'b0, 1'b0});
            @(negedge Clk);
        end
        rsp0_ready = 1'b1;
        @(negedge Clk);
        rsp0_ready = 1'b0;
        #1;
        check("bp_grant1", {req1_ready, rsp0_valid, busy}, 3'b100);
        @(negedge Clk);
        req1_valid = 1'b0;
        check("bp_start1", {mult_start, mult_a, mult_b}, {1'b1, 8'h05, 8'h06});
        n = 0;
        while (!rsp1_valid && n < 100) begin
            @(negedge Clk); n++;
        end
        check("bp_rsp1", {rsp1_valid, rsp1_data, rsp0_valid},
              {1'b1, 16'h001E, 1'b0});
        rsp1_ready = 1'b1;
        @(negedge Clk);
        rsp1_ready = 1'b0;
        check("bp_idle", busy, 1'b0);

        // Reset in WAIT followed by a late done pulse.
        model_en = 1'b0;
        set_req(0, 1'b1, 8'h09, 8'h09);
        #1;
        check("rw_ready", req0_ready, 1'b1);
        @(negedge Clk);
        req0_valid = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        check("rw_in_wait", {busy, mult_start}, 2'b10);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        check("rw_outs_zero",
              {busy, mult_start, mult_a, mult_b, rsp0_valid, rsp1_valid,
               rsp0_data, rsp_err, req0_ready, req1_ready}, 32'h0);
        @(negedge Clk);
        @(negedge Clk);
        force_res  = 16'hBEEF;
        force_done = 1'b1;
        @(negedge Clk);
        force_done = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            if (busy || rsp0_valid || rsp1_valid) bad = 1'b1;
        end
        check("rw_late_done_ignored", bad, 1'b0);
        model_en = 1'b1;
        run_job(0, 8'h09, 8'h09, 16'h0051, "rw_next");

`ifdef MULT_SHARE_TIMEOUT_EN
        model_en = 1'b0;
        set_req(0, 1'b1, 8'h02, 8'h03);
        #1;
        check("to_ready", req0_ready, 1'b1);
        @(negedge Clk);
        req0_valid = 1'b0;
        n = 0;
        while (!rsp0_valid && n < 100) begin
            @(negedge Clk); n++;
        end
        check("to_latency", n, 33);
        check("to_rsp", {rsp0_valid, rsp0_data, rsp_err}, {1'b1, 16'h0, 1'b1});
        force_res  = 16'h1234;
        force_done = 1'b1;
        @(negedge Clk);
        force_done = 1'b0;
        @(negedge Clk);
        check("to_done_ignored", {rsp0_valid, rsp0_data, rsp_err},
              {1'b1, 16'h0, 1'b1});
        rsp0_ready = 1'b1;
        @(negedge Clk);
        rsp0_ready = 1'b0;
        check("to_idle", {busy, rsp0_valid}, 2'b00);
        model_en = 1'b1;
`else
        // Without the watchdog WAIT holds until mult_done.
        model_en = 1'b0;
        set_req(0, 1'b1, 8'h02, 8'h03);
        #1;
        check("nw_ready", req0_ready, 1'b1);
        @(negedge Clk);
        req0_valid = 1'b0;
        repeat (60) @(negedge Clk);
        check("nw_still_wait", {busy, rsp0_valid, rsp_err}, 3'b100);
        force_res  = 16'h1234;
        force_done = 1'b1;
        @(negedge Clk);
        force_done = 1'b0;
        @(negedge Clk);
        check("nw_rsp", {rsp0_valid, rsp0_data, rsp_err},
              {1'b1, 16'h1234, 1'b0});
        rsp0_ready = 1'b1;
        @(negedge Clk);
        rsp0_ready = 1'b0;
        check("nw_idle", {busy, rsp0_valid}, 2'b00);
        model_en = 1'b1;
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
